mips_muldiv_unit: RTL and testbench
===================================

Name: mips_muldiv_unit

Overview:
- Iterative HI/LO multiply/divide unit, directly downstream of the harvard CPU datapath's register-read stage.
- Consumes rs/rt operands plus a decoded op: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Owns the architectural HI/LO registers, which feed the datapath result mux for MFHI/MFLO.
- Asserts busy so the datapath stalls PC and register writeback while an operation is in flight.

Parameters:
- XLEN, 32, operand width; HI/LO width.
- CNT_W, 6, iteration counter width (must hold XLEN).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state.
- clk_enable  input  1  global advance enable; when 0 all state holds.
- op_valid  input  1  op/operands valid this cycle.
- op  input  3  001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; other codes are ignored.
- rs_val  input  XLEN  operand A: multiplicand, dividend, or MTHI/MTLO source.
- rt_val  input  XLEN  operand B: multiplier or divisor.
- busy  output  1  operation in flight; datapath must stall.
- done  output  1  one-cycle pulse when HI/LO take a mul/div result.
- hi  output  XLEN  HI register.
- lo  output  XLEN  LO register.

Behaviour:
- Reset (reset=0, async): state=IDLE; counter=0; hi=lo=0; busy=0; done=0; all internal accumulators 0. An operation in flight is aborted and no partial result is written.
- Accepted operation: the unit samples only on a rising edge with clk_enable=1. clk_enable=0 freezes FSM, counter, accumulators, hi/lo and done.
- States:
  - IDLE -> MUL or DIV on accept of a mul/div op.
  - MUL/DIV -> FIX after XLEN iterations.
  - FIX -> IDLE.
- IDLE:
  - op_valid with MTHI/MTLO: write hi or lo = rs_val on that edge. busy stays 0; done stays 0.
  - op_valid with a mul/div op: latch operand magnitudes (abs value for signed ops), latch the sign flags, set counter=0, busy=1 from the next cycle.
- MUL: shift-add, one multiplier bit per edge, LSB first. Uses a 2*XLEN product register.
- DIV: restoring division, one quotient bit per edge, MSB first. Uses an XLEN+1-bit partial remainder.
- Counter increments each iteration edge; after XLEN iterations the FSM enters FIX.
- FIX edge:
  - Apply sign fixup, then write {hi,lo}.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - DIVU/MULTU: no fixup.
  - done=1 for exactly the following cycle; busy=0 from the same point.
- Latency: accept edge E0; iterations E1..E32; FIX at E33. busy is high for 33 cycles; done and new hi/lo are visible after E33.
- op_valid while busy=1: ignored, including MTHI/MTLO. hi/lo hold their old values until FIX.
- Divide by zero (DIV or DIVU): full latency still applies; lo=0xFFFFFFFF, hi=rs_val, no sign fixup.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. This is the natural result of the abs/negate method.
- Back-to-back: a new op may be accepted on the edge that leaves FIX->IDLE is complete, i.e. on the first cycle where busy=0.
- Every edge with clk_enable=0 extends latency by one cycle.

Test Plan:
1. MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> busy high exactly 33 cycles; done single pulse; hi=0xFFFFFFFE, lo=0x00000001.
2. MULT rs=0xFFFFFFFD (-3) rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIVU 7/2 -> lo=3, hi=1.
3. DIV rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
4. DIVU rs=0x1234 rt=0 -> lo=0xFFFFFFFF, hi=0x1234 after 33 cycles. MTHI 0xCAFEF00D in IDLE -> hi updates next edge, busy stays 0, lo unchanged.
5. Start MULT 5*6; pulse MTLO 0xDEAD and a second MULT while busy -> both ignored, final lo=30, hi=0. Assert reset low at iteration 10 -> hi=lo=0, busy=0 immediately, no done pulse.
6. DIVU 100/7 with clk_enable held low for 5 cycles mid-iteration -> busy high 38 cycles, lo=14, hi=2, single done pulse.

Source files
------------

// File: rtl/mips_muldiv_if.sv
// mips_muldiv_if: datapath <-> HI/LO mul/div unit bus.
// Ports: op_valid/op/rs_val/rt_val (request), busy/done (status), hi/lo (architectural HI/LO).
// master = CPU datapath side, slave = mips_muldiv_unit side.
interface mips_muldiv_if #(parameter int XLEN = 32);
    logic            op_valid;
    logic [2:0]      op;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    modport master (output op_valid, op, rs_val, rt_val, input busy, done, hi, lo);
    modport slave  (input op_valid, op, rs_val, rt_val, output busy, done, hi, lo);
endinterface

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, plus MTHI/MTLO.
// Ports: clk, reset (async active-low), clk_enable (global advance),
//        bus (slave): op_valid/op/rs_val/rt_val in; busy/done/hi/lo out.
module mips_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input logic          clk,
    input logic          reset,
    input logic          clk_enable,
    mips_muldiv_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_FIX = 2'd3;
    localparam logic [2:0] OP_MULT = 3'd1, OP_DIV = 3'd3, OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6;
    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   a, b, quo, rem, hi_r, lo_r;
    logic [2*XLEN-1:0] prod;
    logic              neg_res, neg_rem, is_div, done_r;
    logic [XLEN:0]     mul_sum, rem_sh, diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, rs_abs, rt_abs;
    logic              sgn, is_md;
    always_comb begin
        sgn      = bus.op == OP_MULT || bus.op == OP_DIV;
        is_md    = bus.op >= OP_MULT && bus.op <= OP_DIVU;
        rs_abs   = (sgn && bus.rs_val[XLEN-1]) ? -bus.rs_val : bus.rs_val;
        rt_abs   = (sgn && bus.rt_val[XLEN-1]) ? -bus.rt_val : bus.rt_val;
        // Shift-add: low half of prod holds the not-yet-consumed multiplier bits.
        mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, a} : {(XLEN+1){1'b0}});
        // Restoring divide: quo starts as the dividend and shifts quotient bits in from the right.
        rem_sh   = {rem, quo[XLEN-1]};
        diff     = rem_sh - {1'b0, b};
        prod_fix = neg_res ? -prod : prod;
        // A zero divisor yields an all-ones quotient and rem = |dividend|; the remainder
        // fixup then restores rs_val exactly, so only the quotient fixup is suppressed.
        quo_fix  = (b == '0) ? '1 : (neg_res ? -quo : quo);
        rem_fix  = neg_rem ? -rem : rem;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            a       <= '0;
            b       <= '0;
            quo     <= '0;
            rem     <= '0;
            prod    <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            is_div  <= 1'b0;
            done_r  <= 1'b0;
        end else if (clk_enable) begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: if (bus.op_valid) begin
                    if (bus.op == OP_MTHI) hi_r <= bus.rs_val;
                    if (bus.op == OP_MTLO) lo_r <= bus.rs_val;
                    if (is_md) begin
                        state   <= (bus.op >= OP_DIV) ? S_DIV : S_MUL;
                        is_div  <= bus.op >= OP_DIV;
                        a       <= rs_abs;
                        b       <= rt_abs;
                        prod    <= {{XLEN{1'b0}}, rt_abs};
                        quo     <= rs_abs;
                        rem     <= '0;
                        cnt     <= '0;
                        neg_res <= sgn && (bus.rs_val[XLEN-1] ^ bus.rt_val[XLEN-1]);
                        neg_rem <= sgn && bus.rs_val[XLEN-1];
                    end
                end
                S_MUL: begin
                    prod  <= {mul_sum, prod[XLEN-1:1]};
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == CNT_W'(XLEN-1)) ? S_FIX : S_MUL;
                end
                S_DIV: begin
                    rem   <= diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
                    quo   <= {quo[XLEN-2:0], ~diff[XLEN]};
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == CNT_W'(XLEN-1)) ? S_FIX : S_DIV;
                end
                S_FIX: begin
                    hi_r   <= is_div ? rem_fix : prod_fix[2*XLEN-1:XLEN];
                    lo_r   <= is_div ? quo_fix : prod_fix[XLEN-1:0];
                    done_r <= 1'b1;
                    state  <= S_IDLE;
                end
            endcase
        end
    end
    assign bus.busy = state != S_IDLE;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit: table-driven checks of mips_muldiv_unit plus stall/abort/freeze sequences.
module tb_mips_muldiv_unit;
    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs, rt, hi, lo;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clk_enable = 1'b1;
    int errors = 0;
    int checks = 0;
    vec_t v[13];
    mips_muldiv_if #(.XLEN(32)) bus ();
    mips_muldiv_unit dut (.clk(clk), .reset(rst_n), .clk_enable(clk_enable), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask
    task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int bcyc, output int dcnt);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op = o;
        bus.rs_val = a;
        bus.rt_val = b;
        @(negedge clk);
        bus.op_valid = 1'b0;
        bcyc = 0;
        dcnt = 0;
        while (bus.busy && bcyc < 100) begin
            bcyc++;
            @(negedge clk);
            dcnt += int'(bus.done);
        end
        @(negedge clk);
        dcnt += int'(bus.done);
    endtask
    initial begin
        int n, d;
        logic md;
        v[0]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        v[1]  = '{3'd1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        v[2]  = '{3'd4, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
        v[3]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        v[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        v[5]  = '{3'd4, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
        v[6]  = '{3'd5, 32'hCAFEF00D, 32'h00000000, 32'hCAFEF00D, 32'hFFFFFFFF};
        v[7]  = '{3'd6, 32'h12345678, 32'h00000000, 32'hCAFEF00D, 32'h12345678};
        v[8]  = '{3'd3, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        v[9]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        v[10] = '{3'd3, 32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2};
        v[11] = '{3'd0, 32'h55555555, 32'h33333333, 32'h00000002, 32'hFFFFFFF2};
        v[12] = '{3'd2, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        bus.op_valid = 1'b0;
        bus.op = 3'd0;
        bus.rs_val = '0;
        bus.rt_val = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_hi", bus.hi, 32'd0);
        chk("reset_lo", bus.lo, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 13; i++) begin
            md = v[i].op >= 3'd1 && v[i].op <= 3'd4;
            run(v[i].op, v[i].rs, v[i].rt, n, d);
            chk($sformatf("v%0d_hi", i), bus.hi, v[i].hi);
            chk($sformatf("v%0d_lo", i), bus.lo, v[i].lo);
            chk($sformatf("v%0d_busy_cycles", i), 32'(n), md ? 32'd33 : 32'd0);
            chk($sformatf("v%0d_done_pulses", i), 32'(d), md ? 32'd1 : 32'd0);
        end
        // Requests while busy are ignored; HI/LO hold until the result lands.
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op = 3'd1; bus.rs_val = 32'd5; bus.rt_val = 32'd6;
        @(negedge clk);
        n = int'(bus.busy);
        bus.op = 3'd6; bus.rs_val = 32'h0000DEAD;
        @(negedge clk);
        n += int'(bus.busy);
        bus.op = 3'd1; bus.rs_val = 32'd9; bus.rt_val = 32'd9;
        @(negedge clk);
        n += int'(bus.busy);
        bus.op_valid = 1'b0;
        chk("busy_hold_hi", bus.hi, 32'd1);
        chk("busy_hold_lo", bus.lo, 32'd0);
        d = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n += int'(bus.busy);
            d += int'(bus.done);
        end
        @(negedge clk);
        d += int'(bus.done);
        chk("ignore_busy_cycles", 32'(n), 32'd33);
        chk("ignore_done_pulses", 32'(d), 32'd1);
        chk("ignore_hi", bus.hi, 32'd0);
        chk("ignore_lo", bus.lo, 32'd30);
        // Asynchronous reset at iteration 10 aborts without writing a result.
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op = 3'd2; bus.rs_val = 32'h12345678; bus.rt_val = 32'h9ABCDEF0;
        @(negedge clk);
        bus.op_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_hi", bus.hi, 32'd0);
        chk("abort_lo", bus.lo, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        d = 0;
        repeat (40) begin
            @(negedge clk);
            n += int'(bus.busy);
            d += int'(bus.done);
        end
        chk("abort_no_busy", 32'(n), 32'd0);
        chk("abort_no_done", 32'(d), 32'd0);
        // clk_enable low for 5 cycles mid-iteration stretches busy to 38 cycles.
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op = 3'd4; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
        @(negedge clk);
        bus.op_valid = 1'b0;
        n = int'(bus.busy);
        d = 0;
        repeat (9) begin
            @(negedge clk);
            n += int'(bus.busy);
        end
        clk_enable = 1'b0;
        repeat (5) begin
            @(negedge clk);
            n += int'(bus.busy);
            d += int'(bus.done);
        end
        clk_enable = 1'b1;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n += int'(bus.busy);
            d += int'(bus.done);
        end
        chk("freeze_busy_cycles", 32'(n), 32'd38);
        chk("freeze_hi", bus.hi, 32'd2);
        chk("freeze_lo", bus.lo, 32'd14);
        // Back-to-back: accept on the first cycle busy is low.
        bus.op_valid = 1'b1; bus.op = 3'd2; bus.rs_val = 32'd3; bus.rt_val = 32'd4;
        @(negedge clk);
        bus.op_valid = 1'b0;
        chk("b2b_accept_busy", 32'(bus.busy), 32'd1);
        d += int'(bus.done);
        chk("freeze_done_pulses", 32'(d), 32'd1);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("b2b_busy_cycles", 32'(n), 32'd33);
        chk("b2b_done", 32'(bus.done), 32'd1);
        chk("b2b_hi", bus.hi, 32'd0);
        chk("b2b_lo", bus.lo, 32'd12);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
